// File: rtl/branch_pkg.sv
// Branch op encoding shared with decode and the BranchUnit, plus the
// controller state encoding and per-op operand/link classification.
package branch_pkg;

  localparam logic [3:0] BR_NONE   = 4'd0;
  localparam logic [3:0] BR_JR     = 4'd1;
  localparam logic [3:0] BR_J      = 4'd2;
  localparam logic [3:0] BR_JAL    = 4'd3;
  localparam logic [3:0] BR_BAL    = 4'd4;
  localparam logic [3:0] BR_BGEZAL = 4'd5;
  localparam logic [3:0] BR_BLTZ   = 4'd6;
  localparam logic [3:0] BR_BGEZ   = 4'd7;
  localparam logic [3:0] BR_BLTZAL = 4'd8;
  localparam logic [3:0] BR_B      = 4'd9;
  localparam logic [3:0] BR_BEQ    = 4'd10;
  localparam logic [3:0] BR_BNE    = 4'd11;
  localparam logic [3:0] BR_BLEZ   = 4'd12;
  localparam logic [3:0] BR_BGTZ   = 4'd13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    REDIR = 2'd2
  } branchState_t;

  function automatic logic needs_A(input logic [3:0] op);
    case (op)
      BR_JR, BR_BGEZAL, BR_BLTZ, BR_BGEZ, BR_BLTZAL,
      BR_BLEZ, BR_BGTZ, BR_BEQ, BR_BNE: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  function automatic logic needs_B(input logic [3:0] op);
    return (op == BR_BEQ) || (op == BR_BNE);
  endfunction

  function automatic logic is_link(input logic [3:0] op);
    case (op)
      BR_JAL, BR_BAL, BR_BGEZAL, BR_BLTZAL: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  // Ops 14/15 are reserved; NONE is not a branch.
  function automatic logic isBranchOp(input logic [3:0] op);
    return (op != BR_NONE) && (op <= BR_BGTZ);
  endfunction

endpackage

// File: rtl/branch_perf_cnt.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module branch_perf_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      count <= '0;
    else if (inc && (count != {CNT_W{1'b1}}))
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch sequencer: captures one branch, waits for operands,
// fires the BranchUnit for a single cycle and hands taken targets to fetch.
//
// state | meaning
// IDLE  | no branch held; accept a legal op from decode
// EVAL  | branch held, IF/ID stalled until required operands are ready
// REDIR | taken target offered to fetch until accepted
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int         CNT_W    = 16,
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_BranchCtrl_valid,
  input  logic [3:0]       i_BranchCtrl_brOP,
  input  logic [31:0]      i_BranchCtrl_PC,
  input  logic [25:0]      i_BranchCtrl_target,
  input  logic             i_BranchCtrl_A_rdy,
  input  logic             i_BranchCtrl_B_rdy,
  input  logic             i_BranchCtrl_kill,
  input  logic [31:0]      i_BranchUnit_PC,
  input  logic             i_BranchUnit_clr,
  input  logic             i_BranchCtrl_fetch_rdy,
  output logic [3:0]       o_BranchUnit_brOP,
  output logic [31:0]      o_BranchUnit_PC,
  output logic [25:0]      o_BranchUnit_target,
  output logic             o_BranchCtrl_stall,
  output logic             o_BranchCtrl_redir_valid,
  output logic [31:0]      o_BranchCtrl_redir_PC,
  output logic             o_BranchCtrl_flush,
  output logic             o_BranchCtrl_link_we,
  output logic [4:0]       o_BranchCtrl_link_addr,
  output logic [31:0]      o_BranchCtrl_link_data,
  output logic [CNT_W-1:0] o_BranchCtrl_br_cnt,
  output logic [CNT_W-1:0] o_BranchCtrl_taken_cnt,
  output logic [CNT_W-1:0] o_BranchCtrl_stall_cnt
);

  branchState_t state, stateNext;
  logic [3:0]   opQ;
  logic [31:0]  pcQ;
  logic [25:0]  targetQ;
  logic [31:0]  redirPcQ;
  logic         opsReady;
  logic         captureEn;
  logic         evalFire;
  logic         takenInc;
  logic         stallInc;

  assign opsReady = (!needs_A(opQ) || i_BranchCtrl_A_rdy) &&
                    (!needs_B(opQ) || i_BranchCtrl_B_rdy);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      opQ      <= BR_NONE;
      pcQ      <= '0;
      targetQ  <= '0;
      redirPcQ <= '0;
    end else begin
      if (captureEn) begin
        opQ     <= i_BranchCtrl_brOP;
        pcQ     <= i_BranchCtrl_PC;
        targetQ <= i_BranchCtrl_target;
      end
      if (evalFire)
        redirPcQ <= i_BranchUnit_PC;
    end
  end

  // Kill wins in every state: no capture, no evaluation, no handshake.
  always_comb begin
    stateNext                = state;
    captureEn                = 1'b0;
    evalFire                 = 1'b0;
    takenInc                 = 1'b0;
    stallInc                 = 1'b0;
    o_BranchUnit_brOP        = BR_NONE;
    o_BranchCtrl_stall       = 1'b0;
    o_BranchCtrl_redir_valid = 1'b0;
    o_BranchCtrl_flush       = 1'b0;
    o_BranchCtrl_link_we     = 1'b0;
    o_BranchCtrl_link_data   = '0;
    case (state)
      IDLE: begin
        if (!i_BranchCtrl_kill && i_BranchCtrl_valid && isBranchOp(i_BranchCtrl_brOP)) begin
          captureEn = 1'b1;
          stateNext = EVAL;
        end
      end
      EVAL: begin
        o_BranchCtrl_stall = 1'b1;
        if (i_BranchCtrl_kill) begin
          stateNext = IDLE;
        end else if (opsReady) begin
          evalFire          = 1'b1;
          o_BranchUnit_brOP = opQ;
          if (is_link(opQ)) begin
            o_BranchCtrl_link_we   = 1'b1;
            o_BranchCtrl_link_data = pcQ + 32'd8;
          end
          if (i_BranchUnit_clr) begin
            takenInc  = 1'b1;
            stateNext = REDIR;
          end else begin
            stateNext = IDLE;
          end
        end else begin
          stallInc = 1'b1;
        end
      end
      REDIR: begin
        if (i_BranchCtrl_kill) begin
          stateNext = IDLE;
        end else begin
          o_BranchCtrl_redir_valid = 1'b1;
          if (i_BranchCtrl_fetch_rdy) begin
            o_BranchCtrl_flush = 1'b1;
            stateNext          = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign o_BranchUnit_PC        = pcQ;
  assign o_BranchUnit_target    = targetQ;
  assign o_BranchCtrl_redir_PC  = redirPcQ;
  assign o_BranchCtrl_link_addr = LINK_REG;

  branch_perf_cnt #(.CNT_W(CNT_W)) uBrCnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .inc     (evalFire),
    .count   (o_BranchCtrl_br_cnt)
  );

  branch_perf_cnt #(.CNT_W(CNT_W)) uTakenCnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .inc     (takenInc),
    .count   (o_BranchCtrl_taken_cnt)
  );

  branch_perf_cnt #(.CNT_W(CNT_W)) uStallCnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .inc     (stallInc),
    .count   (o_BranchCtrl_stall_cnt)
  );

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed branch sequences, scoreboarded evaluation
// and redirect events, plus a narrow-counter instance for saturation.
module tb_branch_ctrl;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  brOp = '0;
  logic [31:0] pc = '0;
  logic [25:0] target = '0;
  logic        aRdy = 1'b0;
  logic        bRdy = 1'b0;
  logic        kill = 1'b0;
  logic [31:0] buPc = '0;
  logic        buClr = 1'b0;
  logic        fetchRdy = 1'b0;

  logic [3:0]  uBrOp;
  logic [31:0] uPc;
  logic [25:0] uTgt;
  logic        stall, redirValid, flush, linkWe;
  logic [31:0] redirPc, linkData;
  logic [4:0]  linkAddr;
  logic [15:0] brCnt, takenCnt, stallCnt;

  logic [3:0]  sBrOp;
  logic [31:0] sPc, sRedirPc, sLinkData;
  logic [25:0] sTgt;
  logic        sStall, sRedirValid, sFlush, sLinkWe;
  logic [4:0]  sLinkAddr;
  logic [2:0]  sBrCnt, sTakenCnt, sStallCnt;

  int nTests = 0;
  int nFail = 0;
  int eBr = 0;
  int eTaken = 0;
  int eStall = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic        linkWe;
    logic [31:0] linkData;
  } evalExp_t;

  evalExp_t    evalQ[$];
  logic [31:0] redirQ[$];

  always #5 clk = ~clk;

  branch_ctrl #(.CNT_W(16), .LINK_REG(5'd31)) dut (
    .i_clk(clk), .i_rst_n(rstN),
    .i_BranchCtrl_valid(valid), .i_BranchCtrl_brOP(brOp),
    .i_BranchCtrl_PC(pc), .i_BranchCtrl_target(target),
    .i_BranchCtrl_A_rdy(aRdy), .i_BranchCtrl_B_rdy(bRdy),
    .i_BranchCtrl_kill(kill), .i_BranchUnit_PC(buPc),
    .i_BranchUnit_clr(buClr), .i_BranchCtrl_fetch_rdy(fetchRdy),
    .o_BranchUnit_brOP(uBrOp), .o_BranchUnit_PC(uPc),
    .o_BranchUnit_target(uTgt), .o_BranchCtrl_stall(stall),
    .o_BranchCtrl_redir_valid(redirValid), .o_BranchCtrl_redir_PC(redirPc),
    .o_BranchCtrl_flush(flush), .o_BranchCtrl_link_we(linkWe),
    .o_BranchCtrl_link_addr(linkAddr), .o_BranchCtrl_link_data(linkData),
    .o_BranchCtrl_br_cnt(brCnt), .o_BranchCtrl_taken_cnt(takenCnt),
    .o_BranchCtrl_stall_cnt(stallCnt)
  );

  branch_ctrl #(.CNT_W(3), .LINK_REG(5'd31)) dutSmall (
    .i_clk(clk), .i_rst_n(rstN),
    .i_BranchCtrl_valid(valid), .i_BranchCtrl_brOP(brOp),
    .i_BranchCtrl_PC(pc), .i_BranchCtrl_target(target),
    .i_BranchCtrl_A_rdy(aRdy), .i_BranchCtrl_B_rdy(bRdy),
    .i_BranchCtrl_kill(kill), .i_BranchUnit_PC(buPc),
    .i_BranchUnit_clr(buClr), .i_BranchCtrl_fetch_rdy(fetchRdy),
    .o_BranchUnit_brOP(sBrOp), .o_BranchUnit_PC(sPc),
    .o_BranchUnit_target(sTgt), .o_BranchCtrl_stall(sStall),
    .o_BranchCtrl_redir_valid(sRedirValid), .o_BranchCtrl_redir_PC(sRedirPc),
    .o_BranchCtrl_flush(sFlush), .o_BranchCtrl_link_we(sLinkWe),
    .o_BranchCtrl_link_addr(sLinkAddr), .o_BranchCtrl_link_data(sLinkData),
    .o_BranchCtrl_br_cnt(sBrCnt), .o_BranchCtrl_taken_cnt(sTakenCnt),
    .o_BranchCtrl_stall_cnt(sStallCnt)
  );

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sat(input int v, input int mx);
    return (v > mx) ? 64'(mx) : 64'(v);
  endfunction

  function automatic evalExp_t mkExp(input logic [3:0] op, input logic lw, input logic [31:0] ld);
    evalExp_t e;
    e.op = op;
    e.linkWe = lw;
    e.linkData = ld;
    return e;
  endfunction

  task automatic checkCnt(input string tag);
    checkEq({tag, "_br"},      brCnt,     sat(eBr, 65535));
    checkEq({tag, "_taken"},   takenCnt,  sat(eTaken, 65535));
    checkEq({tag, "_stall"},   stallCnt,  sat(eStall, 65535));
    checkEq({tag, "_s_br"},    sBrCnt,    sat(eBr, 7));
    checkEq({tag, "_s_taken"}, sTakenCnt, sat(eTaken, 7));
    checkEq({tag, "_s_stall"}, sStallCnt, sat(eStall, 7));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of the cycle after the capture edge.
  task automatic present(input logic [3:0] op, input logic [31:0] p, input logic [25:0] t);
    brOp = op;
    pc = p;
    target = t;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    brOp = BR_NONE;
  endtask

  // Scoreboard: every evaluation and every accepted redirect must match the head of its queue.
  always @(negedge clk) begin : monitor
    evalExp_t e;
    if (rstN) begin
      if (uBrOp != BR_NONE) begin
        if (evalQ.size() == 0) begin
          checkEq("eval_unexpected", uBrOp, BR_NONE);
        end else begin
          e = evalQ.pop_front();
          checkEq("eval_op", uBrOp, e.op);
          checkEq("eval_linkwe", linkWe, e.linkWe);
          if (e.linkWe) checkEq("eval_linkdata", linkData, e.linkData);
        end
      end else if (linkWe) begin
        checkEq("link_stray", linkWe, 1'b0);
      end
      if (flush) begin
        if (redirQ.size() == 0) checkEq("flush_unexpected", flush, 1'b0);
        else checkEq("flush_pc", redirPc, redirQ.pop_front());
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation exceeded its time bound");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    checkEq("rst_stall", stall, 0);
    checkEq("rst_redir_valid", redirValid, 0);
    checkEq("rst_flush", flush, 0);
    checkEq("rst_link_we", linkWe, 0);
    checkEq("rst_brop", uBrOp, 0);
    checkEq("rst_link_addr", linkAddr, 31);
    checkEq("rst_bu_pc", uPc, 0);
    checkEq("rst_bu_tgt", uTgt, 0);
    checkEq("rst_redir_pc", redirPc, 0);
    checkEq("rst_link_data", linkData, 0);
    checkCnt("rst");
    checkEq("rst_s_ctl", {sStall, sRedirValid, sFlush, sLinkWe, sBrOp}, 0);
    checkEq("rst_s_pc", sPc, 0);
    checkEq("rst_s_tgt", sTgt, 0);
    checkEq("rst_s_redir_pc", sRedirPc, 0);
    checkEq("rst_s_link", {sLinkAddr, sLinkData}, {5'd31, 32'd0});
    @(posedge clk);
    #1 rstN = 1'b1;

    // J taken, fetch ready on the first redirect cycle
    buPc = 32'h00400010; buClr = 1'b1;
    evalQ.push_back(mkExp(BR_J, 1'b0, 32'h0));
    redirQ.push_back(32'h00400010);
    present(BR_J, 32'h00400010, 26'h0100004);
    @(negedge clk);
    checkEq("j_stall", stall, 1);
    checkEq("j_brop", uBrOp, BR_J);
    checkEq("j_bu_pc", uPc, 32'h00400010);
    checkEq("j_bu_tgt", uTgt, 26'h0100004);
    eBr++; eTaken++;
    tick();
    buPc = 32'hDEADBEEF; buClr = 1'b0; fetchRdy = 1'b1;
    @(negedge clk);
    checkEq("j_redir_valid", redirValid, 1);
    checkEq("j_redir_pc", redirPc, 32'h00400010);
    checkEq("j_redir_stall", stall, 0);
    checkEq("j_flush", flush, 1);
    tick();
    fetchRdy = 1'b0;
    @(negedge clk);
    checkEq("j_after_valid", redirValid, 0);
    checkEq("j_after_flush", flush, 0);
    checkCnt("j");

    // BEQ waiting three cycles for rt
    buPc = 32'h00400080; buClr = 1'b0; aRdy = 1'b1; bRdy = 1'b0;
    evalQ.push_back(mkExp(BR_BEQ, 1'b0, 32'h0));
    present(BR_BEQ, 32'h00400040, 26'h0000010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkEq("beq_wait_stall", stall, 1);
      checkEq("beq_wait_brop", uBrOp, 0);
      eStall++;
      tick();
    end
    bRdy = 1'b1;
    @(negedge clk);
    checkEq("beq_eval_stall", stall, 1);
    checkEq("beq_eval_brop", uBrOp, BR_BEQ);
    eBr++;
    tick();
    aRdy = 1'b0; bRdy = 1'b0;
    @(negedge clk);
    checkEq("beq_idle_stall", stall, 0);
    checkEq("beq_no_redir", redirValid, 0);
    checkCnt("beq");

    // BLTZAL not taken still links
    aRdy = 1'b1; buClr = 1'b0; buPc = 32'h00400500;
    evalQ.push_back(mkExp(BR_BLTZAL, 1'b1, 32'h00400108));
    present(BR_BLTZAL, 32'h00400100, 26'h0000040);
    @(negedge clk);
    checkEq("bltzal_link_we", linkWe, 1);
    checkEq("bltzal_link_addr", linkAddr, 31);
    checkEq("bltzal_link_data", linkData, 32'h00400108);
    eBr++;
    tick();
    aRdy = 1'b0;
    @(negedge clk);
    checkEq("bltzal_no_redir", redirValid, 0);
    checkEq("bltzal_link_off", linkWe, 0);
    checkEq("bltzal_idle", stall, 0);

    // BAL taken, fetch back-pressure for five cycles
    buPc = 32'h00400300; buClr = 1'b1;
    evalQ.push_back(mkExp(BR_BAL, 1'b1, 32'h00400208));
    redirQ.push_back(32'h00400300);
    present(BR_BAL, 32'h00400200, 26'h00000FF);
    @(negedge clk);
    checkEq("bal_brop", uBrOp, BR_BAL);
    checkEq("bal_link_we", linkWe, 1);
    eBr++; eTaken++;
    tick();
    buPc = 32'h12345678; buClr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkEq("bal_hold_valid", redirValid, 1);
      checkEq("bal_hold_pc", redirPc, 32'h00400300);
      checkEq("bal_hold_flush", flush, 0);
      tick();
    end
    fetchRdy = 1'b1;
    @(negedge clk);
    checkEq("bal_acc_valid", redirValid, 1);
    checkEq("bal_acc_pc", redirPc, 32'h00400300);
    checkEq("bal_acc_flush", flush, 1);
    tick();
    fetchRdy = 1'b0;
    @(negedge clk);
    checkEq("bal_done_valid", redirValid, 0);
    checkEq("bal_done_flush", flush, 0);
    checkCnt("bal");

    // Kill while evaluating a linking branch that would be taken
    aRdy = 1'b0; buClr = 1'b1; buPc = 32'h00400A00;
    present(BR_BGEZAL, 32'h00400400, 26'h0);
    @(negedge clk);
    checkEq("kille_wait_stall", stall, 1);
    eStall++;
    tick();
    aRdy = 1'b1; kill = 1'b1;
    @(negedge clk);
    checkEq("kille_brop", uBrOp, 0);
    checkEq("kille_link_we", linkWe, 0);
    checkEq("kille_redir", redirValid, 0);
    checkEq("kille_flush", flush, 0);
    tick();
    kill = 1'b0; aRdy = 1'b0;
    @(negedge clk);
    checkEq("kille_idle", stall, 0);
    checkEq("kille_no_redir", redirValid, 0);
    checkCnt("kill_eval");

    // Kill while the redirect is pending
    buPc = 32'h00400600; buClr = 1'b1;
    evalQ.push_back(mkExp(BR_J, 1'b0, 32'h0));
    present(BR_J, 32'h00400500, 26'h0);
    @(negedge clk);
    checkEq("killr_brop", uBrOp, BR_J);
    eBr++; eTaken++;
    tick();
    buClr = 1'b0; kill = 1'b1; fetchRdy = 1'b1;
    @(negedge clk);
    checkEq("killr_valid", redirValid, 0);
    checkEq("killr_flush", flush, 0);
    tick();
    kill = 1'b0; fetchRdy = 1'b0;
    @(negedge clk);
    checkEq("killr_idle_valid", redirValid, 0);
    checkEq("killr_idle_stall", stall, 0);
    checkCnt("kill_redir");

    // Illegal ops and NONE leave the controller idle
    present(4'd14, 32'h00400700, 26'h0);
    @(negedge clk);
    checkEq("op14_stall", stall, 0);
    checkEq("op14_brop", uBrOp, 0);
    present(4'd15, 32'h00400704, 26'h0);
    @(negedge clk);
    checkEq("op15_stall", stall, 0);
    present(BR_NONE, 32'h00400708, 26'h0);
    @(negedge clk);
    checkEq("none_stall", stall, 0);
    checkCnt("illegal");

    // Back-to-back taken jumps push the narrow counters into saturation
    for (int k = 0; k < 6; k++) begin
      buPc = 32'h00401000 + 32'(k * 16); buClr = 1'b1; fetchRdy = 1'b0;
      evalQ.push_back(mkExp(BR_J, 1'b0, 32'h0));
      redirQ.push_back(buPc);
      present(BR_J, 32'h00400800 + 32'(k * 4), 26'h0);
      eBr++; eTaken++;
      tick();
      buClr = 1'b0; fetchRdy = 1'b1;
      tick();
      fetchRdy = 1'b0;
      @(negedge clk);
      checkCnt("sat_taken");
    end

    // Long operand wait drives the 16-bit stall counter to its ceiling
    aRdy = 1'b1; bRdy = 1'b0; buClr = 1'b0; buPc = 32'h00402000;
    evalQ.push_back(mkExp(BR_BNE, 1'b0, 32'h0));
    present(BR_BNE, 32'h00400900, 26'h0);
    repeat (65532) tick();
    eStall += 65532;
    @(negedge clk);
    checkCnt("sat_stall");
    tick();
    eStall++;
    bRdy = 1'b1;
    @(negedge clk);
    checkEq("sat_bne_brop", uBrOp, BR_BNE);
    checkEq("sat_stall_hold", stallCnt, 16'hFFFF);
    eBr++;
    tick();
    aRdy = 1'b0; bRdy = 1'b0;
    @(negedge clk);
    checkCnt("sat_done");

    // Asynchronous reset in the middle of a pending redirect
    buPc = 32'h00400C00; buClr = 1'b1;
    evalQ.push_back(mkExp(BR_J, 1'b0, 32'h0));
    present(BR_J, 32'h00400B00, 26'h0000123);
    tick();
    buClr = 1'b0;
    @(negedge clk);
    checkEq("rstr_valid_before", redirValid, 1);
    #2 rstN = 1'b0;
    #1;
    eBr = 0; eTaken = 0; eStall = 0;
    checkEq("rstr_valid", redirValid, 0);
    checkEq("rstr_pc", redirPc, 0);
    checkEq("rstr_stall", stall, 0);
    checkEq("rstr_flush", flush, 0);
    checkEq("rstr_bu_pc", uPc, 0);
    checkEq("rstr_bu_tgt", uTgt, 0);
    checkEq("rstr_link_addr", linkAddr, 31);
    checkCnt("rstr");
    @(posedge clk);
    #1 rstN = 1'b1;
    @(negedge clk);
    checkEq("rstr_after_valid", redirValid, 0);
    checkCnt("rstr_after");

    checkEq("evalq_left", evalQ.size(), 0);
    checkEq("redirq_left", redirQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
